delay_pulse_gen: RTL and testbench

DELAY_PULSE_GEN -- requirements
Module: delay_pulse_gen

---
 rtl/delay_pulse_gen_pkg.sv | 7 +
 rtl/delay_pulse_gen_counter.sv | 18 +
 rtl/delay_pulse_gen.sv | 64 ++++++
 tb/tb_delay_pulse_gen.sv | 130 +++++++++++++
 4 files changed

// File: rtl/delay_pulse_gen_pkg.sv
// delay_pulse_pkg: FSM state type, default counter width and status counter widths for delay_pulse_gen
package delay_pulse_pkg;
  localparam int DEF_CNT_WIDTH = 32;
  localparam int TRIG_CNT_W = 32;
  localparam int MISS_CNT_W = 16;
  typedef enum logic [1:0] {IDLE, DELAY, WIDTH, HOLDOFF} state_t;
endpackage

// File: rtl/delay_pulse_gen_counter.sv
// pulse_down_counter: loadable down-counter stopping at zero; in clk, reset_n, load, load_val[W], dec; out zero
module pulse_down_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && !zero) cnt <= cnt - W'(1);
  assign zero = cnt == '0;
endmodule

// File: rtl/delay_pulse_gen.sv
// delay_pulse_gen: triggered delayed pulse with holdoff; in clk, reset_n, trig, enable, delay, width, holdoff; out pulse_out, busy, trig_count, miss_count
module delay_pulse_gen
  import delay_pulse_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter     POLARITY  = "POS"
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  trig,
  input  logic                  enable,
  input  logic [CNT_WIDTH-1:0]  delay,
  input  logic [CNT_WIDTH-1:0]  width,
  input  logic [CNT_WIDTH-1:0]  holdoff,
  output logic                  pulse_out,
  output logic                  busy,
  output logic [TRIG_CNT_W-1:0] trig_count,
  output logic [MISS_CNT_W-1:0] miss_count
);
  localparam logic INACTIVE = (POLARITY == "NEG");
  state_t state;
  logic pulse, has_hold, accept, miss, d_zero, w_zero, h_zero;
  logic [CNT_WIDTH-1:0] d_load, w_load, h_load;
  assign accept = trig && enable && state == IDLE;
  assign miss = trig && enable && state != IDLE;
  assign busy = state != IDLE;
  assign pulse_out = pulse ^ INACTIVE;
  assign d_load = delay == '0 ? '0 : delay - CNT_WIDTH'(1);
  assign w_load = width == '0 ? '0 : width - CNT_WIDTH'(1);
  assign h_load = holdoff == '0 ? '0 : holdoff - CNT_WIDTH'(1);
  pulse_down_counter #(.W(CNT_WIDTH)) u_delay (
    .clk, .reset_n, .load(accept), .load_val(d_load), .dec(state == DELAY), .zero(d_zero)
  );
  pulse_down_counter #(.W(CNT_WIDTH)) u_width (
    .clk, .reset_n, .load(accept), .load_val(w_load), .dec(state == WIDTH), .zero(w_zero)
  );
  pulse_down_counter #(.W(CNT_WIDTH)) u_holdoff (
    .clk, .reset_n, .load(accept), .load_val(h_load), .dec(state == HOLDOFF), .zero(h_zero)
  );
  // pulse trails the WIDTH state by one edge so it rises on A+delay+1
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= IDLE;
      pulse      <= 1'b0;
      has_hold   <= 1'b0;
      trig_count <= '0;
      miss_count <= '0;
    end else begin
      pulse <= enable && state == WIDTH;
      if (accept) trig_count <= trig_count + TRIG_CNT_W'(1);
      if (miss && miss_count != '1) miss_count <= miss_count + MISS_CNT_W'(1);
      if (!enable) state <= IDLE;
      else case (state)
        IDLE: if (trig) begin
          state    <= delay == '0 ? WIDTH : DELAY;
          has_hold <= holdoff != '0;
        end
        DELAY:   if (d_zero) state <= WIDTH;
        WIDTH:   if (w_zero) state <= has_hold ? HOLDOFF : IDLE;
        HOLDOFF: if (h_zero) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_delay_pulse_gen.sv
// tb_delay_pulse_gen: random and directed stimulus against a timeline model of accepted pulses
module tb_delay_pulse_gen;
  logic clk = 0, reset_n = 0, trig = 0, enable = 0;
  logic [31:0] delay = 0, width = 0, holdoff = 0;
  logic pulse_pos, pulse_neg, busy_pos, busy_neg;
  logic [31:0] tc_pos, tc_neg;
  logic [15:0] mc_pos, mc_neg;
  int errors = 0, checks = 0;
  longint k = 0, a_end = 0, p_s = 0, p_e = 0;
  bit act = 0;
  int unsigned m_tc = 0, m_mc = 0;
  always #5 clk = ~clk;
  delay_pulse_gen #(.POLARITY("POS")) u_pos (
    .clk(clk), .reset_n(reset_n), .trig(trig), .enable(enable), .delay(delay), .width(width),
    .holdoff(holdoff), .pulse_out(pulse_pos), .busy(busy_pos), .trig_count(tc_pos), .miss_count(mc_pos)
  );
  delay_pulse_gen #(.POLARITY("NEG")) u_neg (
    .clk(clk), .reset_n(reset_n), .trig(trig), .enable(enable), .delay(delay), .width(width),
    .holdoff(holdoff), .pulse_out(pulse_neg), .busy(busy_neg), .trig_count(tc_neg), .miss_count(mc_neg)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got=%0h expected=%0h", tag, k, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    bit exp_p, exp_b;
    exp_b = act && k < a_end;
    exp_p = act && k >= p_s && k <= p_e;
    check({tag, "_pulse_pos"}, pulse_pos, exp_p);
    check({tag, "_pulse_neg"}, pulse_neg, !exp_p);
    check({tag, "_busy"}, busy_pos, exp_b);
    check({tag, "_busy_neg"}, busy_neg, exp_b);
    check({tag, "_trig_count"}, tc_pos, m_tc);
    check({tag, "_trig_count_neg"}, tc_neg, m_tc);
    check({tag, "_miss_count"}, mc_pos, m_mc);
    check({tag, "_miss_count_neg"}, mc_neg, m_mc);
  endtask
  task automatic step(input string tag, input bit t, input bit e);
    bit bb;
    longint wm;
    trig = t;
    enable = e;
    @(posedge clk);
    k++;
    bb = act && (k - 1 < a_end);
    if (!e) act = 0;
    else if (t) begin
      if (!bb) begin
        wm = width == 0 ? 1 : longint'(width);
        act = 1;
        p_s = k + longint'(delay) + 1;
        p_e = k + longint'(delay) + wm;
        a_end = k + longint'(delay) + wm + longint'(holdoff);
        m_tc++;
      end else if (m_mc != 65535) m_mc++;
    end
    #1;
    check_all(tag);
  endtask
  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      delay = $urandom_range(9);
      width = $urandom_range(9);
      holdoff = $urandom_range(9);
      step(tag, 0, 1);
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    reset_n = 1;
    delay = 3; width = 2; holdoff = 4;
    step("r033", 1, 1);
    idle("r033", 12);
    check("r033_single_accept", tc_pos, 1);
    delay = 0; width = 0; holdoff = 0;
    step("r034", 1, 1);
    step("r034", 0, 1);
    step("r034", 1, 1);
    idle("r034", 3);
    delay = 3; width = 2; holdoff = 4;
    step("r035", 1, 1);
    step("r035", 0, 1);
    step("r035", 1, 1);
    for (int i = 0; i < 6; i++) step("r035", 0, 1);
    step("r024", 1, 1);
    step("r035", 1, 1);
    for (int i = 0; i < 12; i++) step("r035", 0, 1);
    delay = 100; width = 5; holdoff = 2;
    step("r036", 1, 1);
    for (int i = 0; i < 39; i++) step("r036", i == 20, 1);
    step("r036", 1, 0);
    for (int i = 0; i < 9; i++) step("r036", 0, 1);
    delay = 1; width = 3; holdoff = 1;
    step("r036", 1, 1);
    idle("r036", 8);
    delay = 2; width = 10; holdoff = 0;
    step("r037", 1, 1);
    for (int i = 0; i < 5; i++) step("r037", 0, 1);
    #2 reset_n = 0;
    #1;
    act = 0; m_tc = 0; m_mc = 0;
    check_all("r037_async");
    @(posedge clk);
    k++;
    #1 reset_n = 1;
    delay = 0; width = 1; holdoff = 0;
    step("r029", 1, 1);
    idle("r029", 3);
    for (int i = 0; i < 1500; i++) begin
      delay = $urandom_range(6);
      width = $urandom_range(5);
      holdoff = $urandom_range(5);
      step("rand", ($urandom % 4) == 0, ($urandom % 25) != 0);
    end
    delay = 100000; width = 1; holdoff = 0;
    step("r038", 1, 1);
    for (int i = 0; i < 65540; i++) step("r038", 1, 1);
    check("r038_miss_sat", mc_pos, 16'hFFFF);
    step("r038", 1, 0);
    step("r038", 1, 1);
    idle("r038", 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
